alu_uart_core: RTL and testbench

// - Serial-command ALU core for the iCEBreaker top level: receives command packets on UART
//   RX, runs signed 32-bit add / multiply / divide, returns the result on UART TX.
// - 8N1, LSB first, idle high; bit period = 8*PRESCALE clk cycles.
// - Self-contained: built-in RX deserializer, packet parser, ALU and TX serializer.

---
 rtl/alu_uart_core.sv | 215 +++++++++++++++++++++
 tb/tb_alu_uart_core.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_uart_core.sv
// alu_uart_core: serial-command ALU. Receives command packets over UART RX,
// runs signed 32-bit add / multiply / divide, and returns the result on UART TX.
// Framing is 8N1, LSB first, idle high, with a bit period of 8*PRESCALE clocks.
//
// Ports:
//   clk  - system clock (rising edge)
//   rst  - asynchronous active-high reset
//   rxd  - UART serial input (asynchronous to clk, 2-FF synchronized)
//   txd  - UART serial output, idle high
//   busy - high from the first header byte until the last response stop bit
//
// Build option: define ALU_UART_ERR_RESP_EN so that an unknown opcode answers with
// the single byte 8'hEE once the packet has been consumed. Without it, an unknown
// opcode is consumed silently.
module alu_uart_core #(
  parameter int PRESCALE = 19,
  parameter int MAX_LEN  = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  output logic busy
);
  localparam logic [15:0] HALF_P  = 16'(4*PRESCALE-1);
  localparam logic [15:0] FULL_P  = 16'(8*PRESCALE-1);
  localparam logic [15:0] LEN_MAX = 16'(MAX_LEN);
  localparam logic [7:0]  OP_ADD  = 8'hAD;
  localparam logic [7:0]  OP_MUL  = 8'h63;
  localparam logic [7:0]  OP_DIV  = 8'h5B;

  typedef enum logic [1:0] {S_HDR, S_OPER, S_EXEC, S_RESP} state_t;
  state_t state_q, state_d;

  // ---------------- RX deserializer ----------------
  logic [1:0]  rxs_q;
  logic        rx_act_q, rx_v_q;
  logic [15:0] rx_cnt_q;
  logic [3:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rx_s;
  assign rx_s = rxs_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_q <= 2'b11; rx_act_q <= 1'b0; rx_v_q <= 1'b0;
      rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
    end else begin
      rxs_q  <= {rxs_q[0], rxd};
      rx_v_q <= 1'b0;
      if (!rx_act_q) begin
        if (!rx_s) begin
          rx_act_q <= 1'b1; rx_cnt_q <= HALF_P; rx_bit_q <= '0;
        end
      end else if (rx_cnt_q != 16'd0) begin
        rx_cnt_q <= rx_cnt_q - 16'd1;
      end else begin
        rx_cnt_q <= FULL_P;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          if (rx_s) rx_act_q <= 1'b0;          // glitch, not a real start bit
        end else if (rx_bit_q == 4'd9) begin
          rx_act_q <= 1'b0;
          rx_v_q   <= rx_s;                    // low stop bit drops the byte
        end else begin
          rx_sh_q <= {rx_s, rx_sh_q[7:1]};
        end
      end
    end
  end

  // ---------------- Parser / ALU ----------------
  logic [15:0] cnt_q, len_q, len_in, len_eff;
  logic [7:0]  opc_q;
  logic [31:0] op_q, acc_q, dvs_q, op_w, prod_w;
  logic [31:0] quo_q, rem_q, dabs_q, q_fin, r_fin;
  logic [32:0] rem_t, sub_t;
  logic [1:0]  op_idx_q;
  logic [5:0]  ex_cnt_q;
  logic [63:0] txbuf_q;
  logic [3:0]  tx_left_q;
  logic        is_div, known, exec_done, resp_en, tx_start, tx_act_q;

  assign len_in   = {rx_sh_q, len_q[7:0]};
  assign len_eff  = (len_in < 16'd4) ? 16'd4 : ((len_in > LEN_MAX) ? LEN_MAX : len_in);
  assign op_w     = {rx_sh_q, op_q[31:8]};
  assign prod_w   = acc_q * op_w;
  assign is_div   = (opc_q == OP_DIV);
  assign known    = (opc_q == OP_ADD) || (opc_q == OP_MUL) || is_div;
  // divider: 1 setup cycle, 32 shift-subtract steps, result read on count 33
  assign exec_done = !is_div || (ex_cnt_q == 6'd33);
  assign rem_t    = {rem_q, quo_q[31]};
  assign sub_t    = rem_t - {1'b0, dabs_q};
  assign tx_start = (state_q == S_RESP) && !tx_act_q && (tx_left_q != 4'd0);
  assign busy     = (state_q != S_HDR) || (cnt_q != 16'd0);
`ifdef ALU_UART_ERR_RESP_EN
  assign resp_en = 1'b1;
`else
  assign resp_en = known;
`endif

  always_comb begin
    q_fin = (acc_q[31] ^ dvs_q[31]) ? -quo_q : quo_q;
    r_fin = acc_q[31] ? -rem_q : rem_q;
    if (dvs_q == 32'd0) begin
      q_fin = 32'hFFFF_FFFF;
      r_fin = acc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR:  if (rx_v_q && cnt_q[1:0] == 2'd3)
                state_d = (len_eff <= 16'd4) ? S_EXEC : S_OPER;
      S_OPER: if (rx_v_q && (cnt_q + 16'd1 == len_q)) state_d = S_EXEC;
      S_EXEC: if (exec_done) state_d = resp_en ? S_RESP : S_HDR;
      S_RESP: if (tx_left_q == 4'd0 && !tx_act_q) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HDR; cnt_q <= '0; len_q <= '0; opc_q <= '0; op_q <= '0;
      acc_q <= '0; dvs_q <= '0; op_idx_q <= '0; ex_cnt_q <= '0;
      quo_q <= '0; rem_q <= '0; dabs_q <= '0; txbuf_q <= '0; tx_left_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_HDR: if (rx_v_q) begin
          cnt_q <= cnt_q + 16'd1;
          case (cnt_q[1:0])
            2'd0: begin opc_q <= rx_sh_q; acc_q <= '0; dvs_q <= '0; op_idx_q <= '0; end
            2'd2: len_q <= {len_q[15:8], rx_sh_q};
            2'd3: len_q <= len_eff;
            default: ;
          endcase
        end
        S_OPER: if (rx_v_q) begin
          cnt_q <= cnt_q + 16'd1;
          op_q  <= op_w;
          // header is 4 bytes, so cnt[1:0]==3 marks the last byte of an operand;
          // a short trailing group never reaches it and is ignored
          if (cnt_q[1:0] == 2'd3) begin
            if (op_idx_q != 2'd2) op_idx_q <= op_idx_q + 2'd1;
            case (opc_q)
              OP_ADD: acc_q <= acc_q + op_w;
              OP_MUL: acc_q <= (op_idx_q == 2'd0) ? op_w : prod_w;
              OP_DIV: if (op_idx_q == 2'd0) acc_q <= op_w;
                      else if (op_idx_q == 2'd1) dvs_q <= op_w;
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          ex_cnt_q <= ex_cnt_q + 6'd1;
          if (is_div) begin
            if (ex_cnt_q == 6'd0) begin
              quo_q  <= acc_q[31] ? -acc_q : acc_q;
              dabs_q <= dvs_q[31] ? -dvs_q : dvs_q;
              rem_q  <= '0;
            end else if (ex_cnt_q <= 6'd32) begin
              rem_q <= sub_t[32] ? rem_t[31:0] : sub_t[31:0];
              quo_q <= {quo_q[30:0], ~sub_t[32]};
            end
          end
          if (exec_done) begin
            ex_cnt_q <= '0;
            cnt_q    <= '0;
            if (is_div) begin
              txbuf_q <= {r_fin, q_fin}; tx_left_q <= 4'd8;
            end else if (known) begin
              txbuf_q <= {32'd0, acc_q}; tx_left_q <= 4'd4;
            end else begin
              txbuf_q <= {56'd0, 8'hEE}; tx_left_q <= resp_en ? 4'd1 : 4'd0;
            end
          end
        end
        S_RESP: if (tx_start) begin
          txbuf_q   <= txbuf_q >> 8;
          tx_left_q <= tx_left_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- TX serializer ----------------
  logic [9:0]  tx_sh_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_act_q <= 1'b0; tx_sh_q <= '1; tx_cnt_q <= '0; tx_bit_q <= '0;
    end else if (tx_start) begin
      tx_act_q <= 1'b1; tx_sh_q <= {1'b1, txbuf_q[7:0], 1'b0};
      tx_cnt_q <= FULL_P; tx_bit_q <= '0;
    end else if (tx_act_q) begin
      if (tx_cnt_q != 16'd0) begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end else begin
        tx_cnt_q <= FULL_P;
        if (tx_bit_q == 4'd9) tx_act_q <= 1'b0;
        else begin
          tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end
    end
  end

  assign txd = !tx_act_q || tx_sh_q[0];
endmodule

// File: tb/tb_alu_uart_core.sv
module tb_alu_uart_core;
  localparam int P    = 2;
  localparam int BIT  = 8*P;
  localparam int HALF = 4*P;

  logic clk = 1'b0, rst, rxd, txd, busy;
  always #5 clk = ~clk;

  alu_uart_core #(.PRESCALE(P), .MAX_LEN(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .busy(busy));

  int vectors = 0, miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] ops[$];

  // TX monitor: deserializes every frame the DUT sends into got_q
  initial begin
    forever begin
      logic [7:0] b;
      @(negedge txd);
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = txd;
      end
      repeat (BIT) @(negedge clk);
      if (!rst) got_q.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd = 1'b0; repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (BIT) @(negedge clk); end
    rxd = 1'b1; repeat (BIT) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // header + operands from ops[] + 'extra' trailing filler bytes
  task automatic send_pkt(input logic [7:0] opc, input int extra);
    logic [15:0] len;
    logic [31:0] w;
    len = 16'(4 + 4*ops.size() + extra);
    send_byte(opc); send_byte(8'h00); send_byte(len[7:0]); send_byte(len[15:8]);
    foreach (ops[k]) begin
      w = ops[k];
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    end
    for (int i = 0; i < extra; i++) send_byte(8'h55);
    ops.delete();
  endtask

  // pop each expected byte against the next received byte, then wait for idle
  task automatic collect(input string tag);
    int t;
    logic [7:0] e, g;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = 0;
      while (got_q.size() == 0 && t < 4000) begin @(negedge clk); t++; end
      if (got_q.size() == 0) begin
        vectors++; miscompares++;
        $error("FAIL %s timeout: no TX byte, expected %02h", tag, e);
        exp_q.delete();
      end else begin
        g = got_q.pop_front();
        check(tag, {24'd0, g}, {24'd0, e});
      end
    end
    t = 0;
    while (busy && t < 4000) begin @(negedge clk); t++; end
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
    repeat (3*BIT) @(negedge clk);
    check({tag, " extra"}, 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask

  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  task automatic div_case(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] m;
    m = div_model(a, b);
    push_word(m[31:0]); push_word(m[63:32]);
    ops.push_back(a); ops.push_back(b);
    send_pkt(8'h5B, 0);
    collect(tag);
  endtask

  initial begin
    rxd = 1'b1; rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset txd", {31'd0, txd}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    push_word(32'd1 + 32'd2);
    ops.push_back(32'd1); ops.push_back(32'd2);
    send_pkt(8'hAD, 0); collect("add");

    push_word(32'hFFFF_FFFF + 32'd1);
    ops.push_back(32'hFFFF_FFFF); ops.push_back(32'd1);
    send_pkt(8'hAD, 0); collect("add wrap");

    push_word(32'd0);
    send_pkt(8'hAD, 0); collect("add none");

    push_word(32'd2 * 32'd3 * 32'd7);
    ops.push_back(32'd2); ops.push_back(32'd3); ops.push_back(32'd7);
    send_pkt(8'h63, 0); collect("mul3");

    push_word(32'h0001_0000 * 32'h0001_0000);
    ops.push_back(32'h0001_0000); ops.push_back(32'h0001_0000);
    send_pkt(8'h63, 0); collect("mul ovf");

    div_case(32'hFFFF_FFF9, 32'd2, "div signed");
    div_case(32'h0000_002A, 32'd0, "div zero");
    div_case(32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    div_case(32'd100, 32'hFFFF_FFF9, "div neg divisor");

    // third operand ignored, two trailing bytes consumed
    begin
      logic [63:0] m;
      m = div_model(32'd100, 32'd7);
      push_word(m[31:0]); push_word(m[63:32]);
      ops.push_back(32'd100); ops.push_back(32'd7); ops.push_back(32'd5);
      send_pkt(8'h5B, 2); collect("div extra");
    end

`ifdef ALU_UART_ERR_RESP_EN
    exp_q.push_back(8'hEE);
`endif
    ops.push_back(32'h1234_5678);
    send_pkt(8'h11, 0); collect("unknown op");

    // reset in the middle of a packet
    send_byte(8'hAD); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    check("busy mid pkt", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst txd", {31'd0, txd}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    push_word(32'd3);
    ops.push_back(32'd1); ops.push_back(32'd2);
    send_pkt(8'hAD, 0); collect("add after rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
